oam_dma_ctrl: RTL
=================

Name: oam_dma_ctrl

Overview:
- Sequences the DMG OAM DMA: a CPU write to FF46 copies 160 bytes from {FF46, 8'h00} into OAM FE00–FE9F.
- Sits beside the bus arbiter. It drives the DMA source address and read strobe into the arbiter and writes OAM directly.
- It also tells the arbiter whether the source is the VRAM bus or the external bus, so the arbiter can steer the CPU away from the bus being used.

Parameters:
- CYC_PER_BYTE, 4, clk2 cycles per byte slot (one M-cycle); legal range 2–8.
- XFER_LEN, 160, bytes per transfer.

Ports:
- clk2  in  1  system clock.
- reset2  in  1  synchronous reset, active-high.
- reg_wr  in  1  single-cycle write strobe for FF46.
- reg_rd  in  1  read strobe for FF46.
- d_in  in  8  CPU write data.
- d_out  out  8  FF46 readback; valid while reg_rd is high, 0x00 otherwise.
- src_data  in  8  byte returned by the arbiter for dma_addr; valid in the last phase of a slot.
- dma_rd  out  1  DMA source read request.
- dma_addr  out  16  DMA source address.
- vram_to_oam  out  1  source lies in 8000–9FFF (VRAM bus).
- dma_addr_ext  out  1  source is not VRAM (external bus).
- dma_run  out  1  DMA owns its source bus.
- oam_addr  out  8  OAM write index.
- oam_din  out  8  OAM write data.
- oam_wr  out  1  single-cycle OAM write strobe.
- dma_done  out  1  single-cycle pulse at transfer completion.
- cpu_a  in  16  CPU address; used only with the optional feature.
- cpu_blocked  out  1  see Optional Feature.

Behaviour:
- Reset values: all outputs 0; base register 0x00; state IDLE; idx 0; phase 0.
- State machine has three states: IDLE, START, XFER. A phase counter cycles 0..CYC_PER_BYTE-1 in START and XFER.
- reg_wr in any state:
  - base <= d_in; state <= START; idx <= 0; phase <= 0.
  - A capture due in that same cycle is dropped.
  - reg_wr has priority over every other event.
- START:
  - Lasts exactly one slot (CYC_PER_BYTE clocks), then moves to XFER.
  - dma_run holds its previous value: high if a transfer was already running (restart), low from IDLE.
- XFER:
  - dma_run = 1 and dma_rd = 1 for the whole slot.
  - dma_addr = {src_hi, idx}.
  - src_hi = base when base < 0xE0, otherwise base - 0x20 (E0–FF map onto C0–DF).
- Capture: at phase CYC_PER_BYTE-1, oam_din <= src_data and oam_addr <= idx. In the next cycle oam_wr = 1 and idx increments.
- Completion: when capturing idx = XFER_LEN-1, the next cycle asserts oam_wr and dma_done together. State returns to IDLE, and dma_run and dma_rd drop in that same cycle.
- Latency:
  - First dma_rd: CYC_PER_BYTE+1 clocks after reg_wr.
  - First oam_wr: 2·CYC_PER_BYTE+1 clocks after reg_wr.
  - Total from reg_wr to dma_done: (XFER_LEN+1)·CYC_PER_BYTE+1 clocks.
- Source steering:
  - vram_to_oam = dma_run & (src_hi[7:5] == 3'b100).
  - dma_addr_ext = dma_run & ~vram_to_oam.
- d_out returns base regardless of state.
- reset2 mid-transfer aborts immediately: no further oam_wr and no dma_done.
- idx is 8 bits and is never compared above XFER_LEN-1, so it does not wrap.

Optional Feature:
- Macro: OAM_DMA_CPU_BLOCK_EN.
- Enabled:
  - cpu_blocked = dma_run & ~(cpu_a >= 16'hFF80 && cpu_a <= 16'hFFFE).
  - The arbiter uses it to return 0xFF to the CPU and suppress CPU writes to the bus.
  - Registered identically to dma_run: no extra latency.
- Disabled: cpu_blocked tied to 0 and cpu_a unused.

Decomposition:
- Shared package (oam_dma_pkg) holds:
  - the state enum (IDLE, START, XFER);
  - the FF46 address constant;
  - OAM_BASE 16'hFE00;
  - the HRAM bounds FF80/FFFE;
  - the echo threshold 0xE0.
- Natural sub-module: oam_dma_slot_timer. It is the phase counter and emits slot_last; it is reused by the top-level sequencer.

Test Plan:
- reg_wr d_in=0xC1, src_data = low byte of dma_addr → 160 oam_wr pulses with oam_addr 0..159, oam_din 0..159, dma_addr C100..C19F. dma_done one cycle after the 160th capture, at clock 645 after reg_wr.
- d_in=0x80 → vram_to_oam=1, dma_addr_ext=0 during XFER. Repeat with d_in=0x40 → vram_to_oam=0, dma_addr_ext=1.
- d_in=0xFE → dma_addr FE00 maps to DE00..DE9F. d_in=0xE3 → C300.
- Restart: reg_wr 0xC0, then reg_wr 0xD0 at idx=50 phase 3 → no oam_wr for idx 50. dma_run stays 1 through START, then oam_addr restarts at 0 with source D000.
- reset2 at idx=80 → all outputs 0 next cycle, no dma_done. reg_rd afterwards returns 0x00.
- OAM_DMA_CPU_BLOCK_EN: during XFER, cpu_a=FF80 → cpu_blocked=0; cpu_a=C000 → 1; cpu_a=FFFF → 1. In IDLE → 0 for all.

Source files
------------

// File: rtl/oam_dma_ctrl_pkg.sv
// Shared state encoding, address map constants and source-page helper for the OAM DMA sequencer.
package oam_dma_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    XFER  = 2'd2
  } dma_state_e;

  localparam logic [15:0] FF46_ADDR = 16'hFF46;
  localparam logic [15:0] OAM_BASE  = 16'hFE00;
  localparam logic [15:0] HRAM_LO   = 16'hFF80;
  localparam logic [15:0] HRAM_HI   = 16'hFFFE;
  localparam logic [7:0]  ECHO_TH   = 8'hE0;

  // Pages E0-FF are echo RAM and are read through their C0-DF image.
  function automatic logic [7:0] src_page(input logic [7:0] base);
    return (base >= ECHO_TH) ? (base - 8'h20) : base;
  endfunction

endpackage

// File: rtl/oam_dma_ctrl_if.sv
// DMA-side bus bundle: source read toward the arbiter, OAM write port and CPU steering.
interface oam_dma_ctrl_if;

  logic [7:0]  src_data;
  logic        dma_rd;
  logic [15:0] dma_addr;
  logic        vram_to_oam;
  logic        dma_addr_ext;
  logic        dma_run;
  logic [7:0]  oam_addr;
  logic [7:0]  oam_din;
  logic        oam_wr;
  logic [15:0] cpu_a;
  logic        cpu_blocked;

  modport master (
    input  src_data, cpu_a,
    output dma_rd, dma_addr, vram_to_oam, dma_addr_ext, dma_run,
           oam_addr, oam_din, oam_wr, cpu_blocked
  );

  modport slave (
    output src_data, cpu_a,
    input  dma_rd, dma_addr, vram_to_oam, dma_addr_ext, dma_run,
           oam_addr, oam_din, oam_wr, cpu_blocked
  );

endinterface

// File: rtl/oam_dma_ctrl_slot_timer.sv
// Byte-slot phase counter for the OAM DMA; slot_last marks the final clock of each M-cycle slot.
module oam_dma_slot_timer #(
  parameter int CYC_PER_BYTE = 4
) (
  input  logic clk2,
  input  logic reset2,
  input  logic clr,
  input  logic en,
  output logic slot_last
);

  localparam int PW = (CYC_PER_BYTE > 1) ? $clog2(CYC_PER_BYTE) : 1;
  localparam logic [PW-1:0] LAST = PW'(CYC_PER_BYTE - 1);

  logic [PW-1:0] phase;

  always_ff @(posedge clk2) begin
    if (reset2 || clr) begin
      phase <= '0;
    end else if (en) begin
      phase <= (phase == LAST) ? '0 : phase + 1'b1;
    end
  end

  assign slot_last = en && (phase == LAST);

endmodule

// File: rtl/oam_dma_ctrl.sv
// DMG OAM DMA sequencer: FF46 write copies XFER_LEN bytes from {base,8'h00} into OAM.
// Optional macro OAM_DMA_CPU_BLOCK_EN drives cpu_blocked for CPU accesses outside HRAM.
module oam_dma_ctrl
  import oam_dma_pkg::*;
#(
  parameter int CYC_PER_BYTE = 4,
  parameter int XFER_LEN     = 160
) (
  input  logic        clk2,
  input  logic        reset2,
  input  logic        reg_wr,
  input  logic        reg_rd,
  input  logic [7:0]  d_in,
  output logic [7:0]  d_out,
  output logic        dma_done,
  oam_dma_ctrl_if.master bus
);

  localparam logic [7:0] LAST_IDX = 8'(XFER_LEN - 1);

  dma_state_e state, next_state;
  logic [7:0] base;
  logic [7:0] idx;
  logic [7:0] src_hi;
  logic       run_q;
  logic [7:0] oam_addr_q;
  logic [7:0] oam_din_q;
  logic       oam_wr_q;
  logic       done_q;
  logic       slot_last;
  logic       capture;

  oam_dma_slot_timer #(.CYC_PER_BYTE(CYC_PER_BYTE)) u_slot (
    .clk2      (clk2),
    .reset2    (reset2),
    .clr       (reg_wr),
    .en        (state != IDLE),
    .slot_last (slot_last)
  );

  assign src_hi  = src_page(base);
  assign capture = (state == XFER) && slot_last;

  always_ff @(posedge clk2) begin
    if (reset2) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    if (reg_wr) begin
      next_state = START;
    end else begin
      case (state)
        START:   if (slot_last) next_state = XFER;
        XFER:    if (slot_last && (idx == LAST_IDX)) next_state = IDLE;
        default: next_state = state;
      endcase
    end
  end

  // dma_run holds through START so a restart keeps the bus claimed.
  always_ff @(posedge clk2) begin
    if (reset2) begin
      base       <= 8'h00;
      idx        <= 8'h00;
      run_q      <= 1'b0;
      oam_addr_q <= 8'h00;
      oam_din_q  <= 8'h00;
      oam_wr_q   <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      oam_wr_q <= 1'b0;
      done_q   <= 1'b0;
      run_q    <= (next_state == XFER) || ((next_state == START) && run_q);
      if (reg_wr) begin
        base <= d_in;
        idx  <= 8'h00;
      end else if (capture) begin
        oam_din_q  <= bus.src_data;
        oam_addr_q <= idx;
        oam_wr_q   <= 1'b1;
        done_q     <= (idx == LAST_IDX);
        idx        <= idx + 8'd1;
      end
    end
  end

  always_comb begin
    bus.dma_rd       = (state == XFER);
    bus.dma_addr     = (state == XFER) ? {src_hi, idx} : 16'h0000;
    bus.dma_run      = run_q;
    bus.vram_to_oam  = run_q && (src_hi[7:5] == 3'b100);
    bus.dma_addr_ext = run_q && (src_hi[7:5] != 3'b100);
    bus.oam_addr     = oam_addr_q;
    bus.oam_din      = oam_din_q;
    bus.oam_wr       = oam_wr_q;
`ifdef OAM_DMA_CPU_BLOCK_EN
    bus.cpu_blocked  = run_q && !((bus.cpu_a >= HRAM_LO) && (bus.cpu_a <= HRAM_HI));
`else
    bus.cpu_blocked  = 1'b0;
`endif
    d_out            = reg_rd ? base : 8'h00;
    dma_done         = done_q;
  end

`ifndef OAM_DMA_CPU_BLOCK_EN
  logic unused_cpu_a;
  assign unused_cpu_a = ^bus.cpu_a;
`endif

endmodule
